irq_ctrl: RTL
=============

IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 The block SHALL have one clock, clk; reset rst_n SHALL be synchronous and active-low.
REQ-002 Port list SHALL be as follows (name, direction, width, meaning):
- clk  in  1  core clock.
- rst_n  in  1  synchronous active-low reset.
- irq_src_i  in  8  external interrupt sources; rising edge requests.
- re_i  in  1  bus read strobe, single cycle.
- we_i  in  1  bus write strobe, single cycle.
- addr_i  in  32  byte address; only addr_i[7:0] is decoded.
- data_i  in  32  write data.
- data_o  out  32  read data, registered.
- interrupt_flag_o  out  32  nonzero requests an async interrupt; feeds the CLINT interrupt_flag_i.
- irq_id_o  out  3  index of the source currently asserted or in service.
REQ-003 Register map (offset, access, meaning):
- 0x00 ENABLE  RW  bits[7:0], per-source enable.
- 0x04 PENDING  R/W1C  bits[7:0].
- 0x08 CLAIM  R = claim, W = complete.
- Other offsets: reads return 0, writes are ignored.

Function
REQ-010 The block SHALL register irq_src_i once (src_q); a rising edge on source i SHALL set pending[i] on the following clock edge.
REQ-011 A W1C write to PENDING and a new edge on the same bit in the same cycle SHALL leave the bit set (set wins).
REQ-012 The controller SHALL implement three states: S_IDLE, S_ASSERT, S_SERVICE.
REQ-013 In S_IDLE, when (pending & enable) != 0, the controller SHALL latch id = lowest set index (fixed priority, 0 highest) and enter S_ASSERT on the next edge.
REQ-014 interrupt_flag_o SHALL be 32'h1 while in S_ASSERT and 32'h0 in every other state; it is registered with the state and carries no combinational path from inputs.
REQ-015 In S_ASSERT, a CLAIM read SHALL:
- return id+1 on data_o one cycle after re_i;
- clear pending[id];
- move the controller to S_SERVICE.
REQ-016 In S_ASSERT, if enable[id] or pending[id] becomes 0 before a claim, the controller SHALL return to S_IDLE on the next edge and deassert the flag.
REQ-017 In S_SERVICE, a CLAIM write with data_i[3:0] == id+1 SHALL return the controller to S_IDLE; a mismatched write SHALL be ignored.
REQ-018 A new edge on the serviced source during S_SERVICE SHALL set its pending bit; that source is re-arbitrated only after completion (no nesting).
REQ-019 A CLAIM read in S_IDLE or S_SERVICE SHALL return 0 and SHALL NOT change state.
REQ-020 Reads SHALL have 1-cycle latency; data_o SHALL hold its value until the next read. Upper bits of ENABLE and PENDING SHALL read as 0.
REQ-021 If re_i and we_i are asserted in the same cycle, the write SHALL take effect and the read SHALL return pre-write contents.
REQ-022 irq_id_o SHALL hold the latched id in S_ASSERT and S_SERVICE and SHALL be 0 in S_IDLE.
REQ-023 Arbitration SHALL complete in one cycle: there is one edge from pending set to S_ASSERT when the controller is idle and the source is enabled.

Reset
REQ-030 While rst_n == 0 at a clock edge, the block SHALL set:
- state = S_IDLE;
- ENABLE, PENDING, src_q = 0;
- data_o, interrupt_flag_o, irq_id_o = 0.
REQ-031 Reset asserted in S_ASSERT or S_SERVICE SHALL abandon the in-flight interrupt with no completion required.
REQ-032 Source levels held high through reset release SHALL NOT generate a pending bit until they fall and rise again.

Verification
REQ-040 ENABLE=0x04, pulse irq_src_i[2] -> PENDING reads 0x04, interrupt_flag_o=0x1 two edges after the pulse edge, irq_id_o=2.
REQ-041 ENABLE=0xFF, sources 5 and 1 rise together -> claim returns 2; after completing with 2, claim returns 6.
REQ-042 In S_SERVICE with id=3, write CLAIM=0x5 -> state unchanged; write CLAIM=0x4 -> S_IDLE.
REQ-043 In S_ASSERT for id=0, write ENABLE=0 -> interrupt_flag_o=0 next edge; a subsequent CLAIM read returns 0.
REQ-044 Same-cycle W1C PENDING=0x01 and a rising edge on source 0 -> PENDING reads 0x01.
REQ-045 Assert rst_n=0 in S_SERVICE with irq_src_i held at 0xFF -> all outputs 0; after release, no flag until a fresh edge.

Source files
------------

// File: rtl/irq_ctrl_if.sv
// Register bus between a bus master and the interrupt controller:
// single-cycle read/write strobes, byte address, write data and registered read data.
interface irq_ctrl_if;
    logic        re_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [31:0] data_o;

    modport master (
        output re_i,
        output we_i,
        output addr_i,
        output data_i,
        input  data_o
    );

    modport slave (
        input  re_i,
        input  we_i,
        input  addr_i,
        input  data_i,
        output data_o
    );
endinterface

// File: rtl/irq_ctrl.sv
// Eight-source edge-triggered interrupt controller with fixed priority (source 0 highest)
// and a claim/complete handshake; drives a single async interrupt request to the CLINT.
module irq_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  irq_src_i,
    irq_ctrl_if.slave   bus,
    output logic [31:0] interrupt_flag_o,
    output logic [2:0]  irq_id_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ASSERT,
        S_SERVICE
    } state_t;

    localparam logic [7:0] ADDR_ENABLE  = 8'h00;
    localparam logic [7:0] ADDR_PENDING = 8'h04;
    localparam logic [7:0] ADDR_CLAIM   = 8'h08;

    state_t      state_reg;
    logic [7:0]  src_q;
    logic        armed_reg;
    logic [7:0]  enable_reg;
    logic [7:0]  pending_reg;
    logic [7:0]  pending_next;
    logic [31:0] data_reg;
    logic        flag_reg;
    logic [2:0]  irq_id_reg;

    logic [7:0]  addr_lo;
    logic        wr_enable;
    logic        wr_pending;
    logic        wr_claim;
    logic        rd_claim;
    logic        claim_rd;
    logic        complete_ok;
    logic [3:0]  claim_val;
    logic [7:0]  rise;
    logic [7:0]  w1c_mask;
    logic [7:0]  claim_clear;
    logic [7:0]  active;
    logic [2:0]  arb_id;
    logic [31:0] rd_data;
    logic        unused_bits;

    assign addr_lo     = bus.addr_i[7:0];
    assign wr_enable   = bus.we_i && (addr_lo == ADDR_ENABLE);
    assign wr_pending  = bus.we_i && (addr_lo == ADDR_PENDING);
    assign wr_claim    = bus.we_i && (addr_lo == ADDR_CLAIM);
    assign rd_claim    = bus.re_i && (addr_lo == ADDR_CLAIM);
    assign claim_rd    = rd_claim && (state_reg == S_ASSERT);
    assign claim_val   = {1'b0, irq_id_reg} + 4'd1;
    assign complete_ok = wr_claim && (bus.data_i[3:0] == claim_val);
    assign active      = pending_reg & enable_reg;
    assign unused_bits = ^{bus.addr_i[31:8], bus.data_i[31:8]};

    // armed_reg masks the first cycle after reset so levels held through reset
    // are not mistaken for rising edges. A new edge always beats a clear.
    for (genvar gi = 0; gi < 8; gi++) begin : g_pending
        assign rise[gi]         = armed_reg & irq_src_i[gi] & ~src_q[gi];
        assign w1c_mask[gi]     = wr_pending & bus.data_i[gi];
        assign claim_clear[gi]  = claim_rd & (irq_id_reg == 3'(gi));
        assign pending_next[gi] = (pending_reg[gi] & ~w1c_mask[gi] & ~claim_clear[gi]) | rise[gi];
    end

    always_comb begin
        arb_id = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (active[i]) begin
                arb_id = 3'(i);
            end
        end
    end

    always_comb begin
        rd_data = 32'd0;
        case (addr_lo)
            ADDR_ENABLE:  rd_data = {24'd0, enable_reg};
            ADDR_PENDING: rd_data = {24'd0, pending_reg};
            ADDR_CLAIM:   rd_data = (state_reg == S_ASSERT) ? {28'd0, claim_val} : 32'd0;
            default:      rd_data = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= S_IDLE;
            src_q       <= 8'd0;
            armed_reg   <= 1'b0;
            enable_reg  <= 8'd0;
            pending_reg <= 8'd0;
            data_reg    <= 32'd0;
            flag_reg    <= 1'b0;
            irq_id_reg  <= 3'd0;
        end else begin
            src_q       <= irq_src_i;
            armed_reg   <= 1'b1;
            pending_reg <= pending_next;
            if (wr_enable) begin
                enable_reg <= bus.data_i[7:0];
            end
            if (bus.re_i) begin
                data_reg <= rd_data;
            end
            case (state_reg)
                S_IDLE: begin
                    if (active != 8'd0) begin
                        state_reg  <= S_ASSERT;
                        flag_reg   <= 1'b1;
                        irq_id_reg <= arb_id;
                    end
                end
                S_ASSERT: begin
                    if (claim_rd) begin
                        state_reg <= S_SERVICE;
                        flag_reg  <= 1'b0;
                    end else if (!enable_reg[irq_id_reg] || !pending_reg[irq_id_reg]) begin
                        state_reg  <= S_IDLE;
                        flag_reg   <= 1'b0;
                        irq_id_reg <= 3'd0;
                    end
                end
                S_SERVICE: begin
                    if (complete_ok) begin
                        state_reg  <= S_IDLE;
                        irq_id_reg <= 3'd0;
                    end
                end
                default: begin
                    state_reg  <= S_IDLE;
                    flag_reg   <= 1'b0;
                    irq_id_reg <= 3'd0;
                end
            endcase
        end
    end

    assign bus.data_o       = data_reg;
    assign interrupt_flag_o = {31'd0, flag_reg};
    assign irq_id_o         = irq_id_reg;

endmodule
